// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper
// Sequences ECP5 EHXPLLL dynamic phase steps (PHASESEL/PHASEDIR/PHASESTEP)
// for one selected PLL output at a time. Each step pulse has programmable
// setup, low/high and settle timing. A net step offset is kept per channel.
// A request is aborted when the synchronised PLL lock drops while busy.
// Clocked from the board reference clock, never from a PLL output.

module pll_phase_stepper #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STEP_WIDTH    = 8,
    parameter int unsigned POS_WIDTH     = 8,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pll_locked,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_channel,
    input  logic                          req_dir,
    input  logic [STEP_WIDTH-1:0]         req_steps,
    output logic                          done,
    output logic                          aborted,
    output logic                          locked_sync,
    output logic [1:0]                    phase_sel,
    output logic                          phase_dir,
    output logic                          phase_step,
    output logic [CHANNELS*POS_WIDTH-1:0] offsets
);

    // One shared cycle counter times every state; it is sized for the
    // longest of the setup, pulse and settle intervals.
    localparam int unsigned MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_T = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    // Bit c is set when channel c exists.
    localparam logic [3:0] CHAN_OK = 4'((1 << CHANNELS) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI,
        SETTLE,
        DONE,
        ABORT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [STEP_WIDTH-1:0]  steps_left;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [POS_WIDTH-1:0]   off_q [CHANNELS];
    logic                   accept;
    logic                   pulse_end;

    assign accept    = req_valid && req_ready;
    assign pulse_end = (state == STEP_HI) && (cnt == PULSE_LAST);

    // Lock synchroniser: shift raw LOCK through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Lock loss while busy overrides every timed exit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!CHAN_OK[req_channel]) begin
                        state_nxt = ABORT;
                    end else if (req_steps == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                if (!locked_sync) begin
                    state_nxt = ABORT;
                end else if (cnt == SETUP_LAST) begin
                    state_nxt = STEP_LO;
                end
            end
            STEP_LO: begin
                if (!locked_sync) begin
                    state_nxt = ABORT;
                end else if (cnt == PULSE_LAST) begin
                    state_nxt = STEP_HI;
                end
            end
            STEP_HI: begin
                if (!locked_sync) begin
                    state_nxt = ABORT;
                end else if (cnt == PULSE_LAST) begin
                    if (steps_left != STEP_WIDTH'(1)) begin
                        state_nxt = STEP_LO;
                    end else if (SETTLE_CYCLES == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!locked_sync) begin
                    state_nxt = ABORT;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and synchronised lock.
    always_comb begin
        locked_sync = sync_q[SYNC_STAGES-1];
        req_ready   = (state == IDLE) && locked_sync;
        done        = (state == DONE);
        aborted     = (state == ABORT);
        phase_step  = (state != STEP_LO);
    end

    // Cycle counter: restarts at zero on every state change.
    always_ff @(posedge clk) begin
        if (!reset_n || (state_nxt != state)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request latch, remaining-step count and per-channel offsets.
    // An offset moves only when a pulse's high phase completes with lock
    // still present, so an abort never counts a partial pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_sel  <= '0;
            phase_dir  <= 1'b0;
            steps_left <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                off_q[c] <= '0;
            end
        end else if (accept) begin
            phase_sel  <= req_channel;
            phase_dir  <= req_dir;
            steps_left <= req_steps;
        end else if (pulse_end && locked_sync) begin
            steps_left <= steps_left - STEP_WIDTH'(1);
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (phase_sel == c[1:0]) begin
                    if (phase_dir) begin
                        off_q[c] <= off_q[c] + POS_WIDTH'(1);
                    end else begin
                        off_q[c] <= off_q[c] - POS_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Flatten the offset registers onto the output bus.
    always_comb begin
        offsets = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            offsets[c*POS_WIDTH +: POS_WIDTH] = off_q[c];
        end
    end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Bench for pll_phase_stepper: two configurations share one stimulus stream.
// Each configuration is compared every cycle against a timeline model built
// from the cycle-index formulas. Directed literal checks pin the model.

module tb_pll_phase_stepper;

    localparam int NI = 2;
    localparam int CHN [NI] = '{4, 3};
    localparam int PW  [NI] = '{8, 4};
    localparam int SS  [NI] = '{2, 1};
    localparam int PP  [NI] = '{2, 1};
    localparam int CC  [NI] = '{16, 0};
    localparam int SY  [NI] = '{2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        pll_locked;
    logic        req_valid;
    logic [1:0]  req_channel;
    logic        req_dir;
    logic [7:0]  req_steps;

    logic [NI-1:0] ready, done, aborted, lsync, pdir, pstep;
    logic [1:0]    psel [NI];
    logic [31:0]   off_a;
    logic [11:0]   off_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pll_phase_stepper #(
        .CHANNELS(4), .STEP_WIDTH(8), .POS_WIDTH(8), .SETUP_CYCLES(2),
        .PULSE_CYCLES(2), .SETTLE_CYCLES(16), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(ready[0]), .req_channel(req_channel),
        .req_dir(req_dir), .req_steps(req_steps), .done(done[0]),
        .aborted(aborted[0]), .locked_sync(lsync[0]), .phase_sel(psel[0]),
        .phase_dir(pdir[0]), .phase_step(pstep[0]), .offsets(off_a)
    );

    pll_phase_stepper #(
        .CHANNELS(3), .STEP_WIDTH(8), .POS_WIDTH(4), .SETUP_CYCLES(1),
        .PULSE_CYCLES(1), .SETTLE_CYCLES(0), .SYNC_STAGES(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(ready[1]), .req_channel(req_channel),
        .req_dir(req_dir), .req_steps(req_steps), .done(done[1]),
        .aborted(aborted[1]), .locked_sync(lsync[1]), .phase_sel(psel[1]),
        .phase_dir(pdir[1]), .phase_step(pstep[1]), .offsets(off_b)
    );

    // ---------------- behavioural model ----------------
    int unsigned hist [NI];
    bit m_active [NI];
    bit m_abort  [NI];
    int m_j [NI];
    int m_len [NI];
    int m_n [NI];
    int m_ch [NI];
    int m_sel [NI];
    bit m_dir [NI];
    int m_off [NI][4];

    function automatic bit exp_lock(input int i);
        return ((hist[i] >> (SY[i] - 1)) & 1) != 0;
    endfunction

    function automatic bit model_ready(input int i);
        return !m_active[i] && !m_abort[i] && exp_lock(i);
    endfunction

    function automatic int get_off(input int i, input int c);
        if (i == 0) return int'(off_a[c*8 +: 8]);
        return int'(off_b[c*4 +: 4]);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit cl;
            int rel;
            cl = exp_lock(i);
            if (!reset_n) begin
                hist[i] = 0;
                m_active[i] = 0;
                m_abort[i] = 0;
                m_sel[i] = 0;
                m_dir[i] = 0;
                for (int c = 0; c < 4; c++) m_off[i][c] = 0;
            end else begin
                if (m_abort[i]) begin
                    m_abort[i] = 0;
                end else if (m_active[i]) begin
                    if (m_j[i] == m_len[i]) begin
                        m_active[i] = 0;
                    end else if (!cl) begin
                        m_active[i] = 0;
                        m_abort[i] = 1;
                    end else begin
                        rel = m_j[i] - SS[i];
                        if (rel > 0 && rel % (2*PP[i]) == 0 && rel / (2*PP[i]) <= m_n[i])
                            m_off[i][m_ch[i]] = (m_off[i][m_ch[i]] + (m_dir[i] ? 1 : -1))
                                                & ((1 << PW[i]) - 1);
                        m_j[i]++;
                    end
                end else if (req_valid && cl) begin
                    m_sel[i] = int'(req_channel);
                    m_dir[i] = req_dir;
                    if (int'(req_channel) >= CHN[i]) begin
                        m_abort[i] = 1;
                    end else begin
                        m_active[i] = 1;
                        m_j[i] = 1;
                        m_n[i] = int'(req_steps);
                        m_ch[i] = int'(req_channel);
                        m_len[i] = (m_n[i] == 0) ? 1 : SS[i] + 2*PP[i]*m_n[i] + CC[i] + 1;
                    end
                end
                hist[i] = ((hist[i] << 1) | int'(pll_locked)) & ((1 << SY[i]) - 1);
            end
        end
    end

    task automatic chk(input string nm, input int inst, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, inst, $time, got, exp);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                int rel;
                bit e_low;
                e_low = 0;
                if (m_active[i] && m_n[i] > 0) begin
                    rel = m_j[i] - SS[i];
                    e_low = rel >= 1 && rel <= 2*PP[i]*m_n[i] && ((rel - 1) % (2*PP[i])) < PP[i];
                end
                chk("locked_sync", i, int'(lsync[i]), int'(exp_lock(i)));
                chk("req_ready", i, int'(ready[i]), int'(model_ready(i)));
                chk("done", i, int'(done[i]), int'(m_active[i] && m_j[i] == m_len[i]));
                chk("aborted", i, int'(aborted[i]), int'(m_abort[i]));
                chk("phase_step", i, int'(pstep[i]), int'(!e_low));
                chk("phase_sel", i, int'(psel[i]), m_sel[i]);
                chk("phase_dir", i, int'(pdir[i]), int'(m_dir[i]));
                for (int c = 0; c < CHN[i]; c++) chk("offset", i * 10 + c, get_off(i, c), m_off[i][c]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready();
        int w;
        w = 0;
        while (!(model_ready(0) && model_ready(1)) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait_timeout", 0, int'(w < 300), 1);
    endtask

    task automatic send(input int ch, input bit dir, input int steps, input int budget,
                        output int tda, output int tdb, output int tab, output int trb,
                        output int tfa, output int tfb, output int sel1);
        wait_ready();
        req_channel = 2'(ch);
        req_dir     = dir;
        req_steps   = 8'(steps);
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tda = -1; tdb = -1; tab = -1; trb = -1; tfa = -1; tfb = -1; sel1 = -1;
        for (int k = 1; k <= budget; k++) begin
            if (k == 1) sel1 = int'(psel[0]);
            if (done[0] && tda < 0) tda = k;
            if (done[1] && tdb < 0) tdb = k;
            if (aborted[1] && tab < 0) tab = k;
            if (ready[1] && trb < 0) trb = k;
            if (!pstep[0] && tfa < 0) tfa = k;
            if (!pstep[1] && tfb < 0) tfb = k;
            if (k < budget) @(negedge clk);
        end
    endtask

    initial begin
        int tda, tdb, tab, trb, tfa, tfb, sel1, ta, tb, nab, tr;
        reset_n = 1'b0; pll_locked = 1'b0; req_valid = 1'b0;
        req_channel = '0; req_dir = 1'b0; req_steps = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_phase_step", 0, int'(pstep[0]), 1);
        chk("reset_phase_sel", 0, int'(psel[0]), 0);
        chk("reset_ready", 0, int'(ready[0]), 0);
        chk("reset_offsets", 0, int'(off_a), 0);
        reset_n = 1'b1;
        pll_locked = 1'b1;

        // ch2 up by 3 with default timing
        send(2, 1'b1, 3, 40, tda, tdb, tab, trb, tfa, tfb, sel1);
        chk("t1_sel_at_T0p1", 0, sel1, 2);
        chk("t1_first_low", 0, tfa, 3);
        chk("t1_done_time", 0, tda, 31);
        chk("t1_done_time", 1, tdb, 8);
        chk("t1_off2", 0, int'(off_a[23:16]), 3);
        chk("t1_off0", 0, int'(off_a[7:0]), 0);

        // zero steps completes immediately
        send(1, 1'b0, 0, 10, tda, tdb, tab, trb, tfa, tfb, sel1);
        chk("t2_done_time", 0, tda, 1);
        chk("t2_done_time", 1, tdb, 1);
        chk("t2_no_pulse", 0, tfa, -1);
        chk("t2_off1", 0, int'(off_a[15:8]), 0);

        // walk ch0 to 7, then +2 wraps the 4-bit counter to -7
        send(0, 1'b1, 7, 50, tda, tdb, tab, trb, tfa, tfb, sel1);
        send(0, 1'b1, 2, 30, tda, tdb, tab, trb, tfa, tfb, sel1);
        chk("t3_wrap_off0", 1, int'(off_b[3:0]), 9);
        chk("t3_off0", 0, int'(off_a[7:0]), 9);

        // channel 3: illegal for the 3-channel instance
        send(3, 1'b1, 1, 30, tda, tdb, tab, trb, tfa, tfb, sel1);
        chk("t4_abort_time", 1, tab, 1);
        chk("t4_ready_time", 1, trb, 2);
        chk("t4_no_pulse", 1, tfb, -1);
        chk("t4_off3", 0, int'(off_a[31:24]), 1);

        // decrement below zero
        send(3, 1'b0, 2, 30, tda, tdb, tab, trb, tfa, tfb, sel1);
        chk("t5_off3_neg", 0, int'(off_a[31:24]), 255);

        // 10 steps on ch1, lock lost during pulse 4 of the default instance
        wait_ready();
        req_channel = 2'd1; req_dir = 1'b1; req_steps = 8'd10; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        ta = -1; tb = -1; nab = 0; tr = -1;
        for (int k = 1; k <= 40; k++) begin
            if (aborted[0]) begin
                nab++;
                if (ta < 0) ta = k;
            end
            if (aborted[1] && tb < 0) tb = k;
            if (k > 30 && ready[0] && tr < 0) tr = k;
            if (k == 15) pll_locked = 1'b0;
            if (k == 22) begin
                req_channel = 2'd0; req_steps = 8'd1; req_valid = 1'b1;
            end
            if (k == 24) req_valid = 1'b0;
            if (k == 30) pll_locked = 1'b1;
            if (k < 40) @(negedge clk);
        end
        chk("t6_abort_time", 0, ta, 18);
        chk("t6_abort_count", 0, nab, 1);
        chk("t6_abort_time", 1, tb, 19);
        chk("t6_off1_partial", 0, int'(off_a[15:8]), 3);
        chk("t6_off1_partial", 1, int'(off_b[7:4]), 8);
        chk("t6_ready_after_lock", 0, tr, 32);

        // reset asserted during settle
        wait_ready();
        req_channel = 2'd2; req_dir = 1'b1; req_steps = 8'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t7_offsets_a", 0, int'(off_a), 0);
        chk("t7_offsets_b", 1, int'(off_b), 0);
        chk("t7_done", 0, int'(done[0]), 0);
        chk("t7_phase_step", 0, int'(pstep[0]), 1);
        chk("t7_phase_sel", 0, int'(psel[0]), 0);
        chk("t7_locked_sync", 0, int'(lsync[0]), 0);
        reset_n = 1'b1;
        nab = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done[0]) nab++;
        end
        chk("t7_no_done_after_reset", 0, nab, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
